fifo_rd_upsizer: RTL

- Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain.
- Pops MEMORY_WIDTH-bit words through the FIFO's r_en/r_empty/rdata interface (rdata is fall-through: valid whenever r_empty=0) and packs RATIO consecutive words into one wide beat.
- Presents each beat on a valid/ready output with a lane mask and last flag.
- flush closes a partial beat at end of message.

---
 rtl/fifo_rd_upsizer_pkg.sv | 13 +
 rtl/fifo_rd_out_stage.sv | 39 +++
 rtl/fifo_rd_upsizer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_rd_upsizer_pkg.sv
// fifo_rd_upsizer_pkg: shared state type and lane-mask helper for the FIFO read-side upsizer
package fifo_rd_upsizer_pkg;

    typedef enum logic {ACC, FLUSH} state_t;

    localparam int MAX_LANES = 64;

    // Low n bits set; callers narrow the result to their lane count
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned n);
        return (n >= MAX_LANES) ? '1 : (MAX_LANES'(1) << n) - MAX_LANES'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_out_stage.sv
// fifo_rd_out_stage: single-entry valid/ready output register holding one packed beat
module fifo_rd_out_stage #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic              r_clk,
    input  logic              rrst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LANES-1:0]  load_mask,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LANES-1:0]  out_mask,
    output logic              out_last
);

    assign free = !out_valid || out_ready;

    // Load a new beat when free; otherwise hold the presented beat until it drains
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= load || (out_valid && !out_ready);
            if (load) begin
                out_data <= load_data;
                out_mask <= load_mask;
                out_last <= load_last;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_upsizer.sv
// fifo_rd_upsizer: packs RATIO consecutive FIFO words into one wide valid/ready beat
module fifo_rd_upsizer
    import fifo_rd_upsizer_pkg::*;
#(
    parameter  int MEMORY_WIDTH = 8,
    parameter  int RATIO        = 4,
    localparam int CNT_W        = $clog2(RATIO + 1)
) (
    input  logic                          r_clk,
    input  logic                          rrst_n,
    input  logic                          r_empty,
    input  logic [MEMORY_WIDTH-1:0]       rdata,
    output logic                          r_en,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MEMORY_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]              out_mask,
    output logic                          out_last,
    output logic [CNT_W-1:0]              words_held
);

    localparam int IDX_W  = $clog2(RATIO);
    localparam int BEAT_W = MEMORY_WIDTH * RATIO;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    state_t                  state, state_nxt;
    logic [MEMORY_WIDTH-1:0] acc [RATIO];
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    last_pend, last_pend_nxt;
    logic                    free, full, complete, load, load_last;
    logic [IDX_W-1:0]        wr_idx;
    logic [RATIO-1:0]        part_mask, load_mask;
    logic [BEAT_W-1:0]       full_beat, part_beat, load_data;

    assign full       = (cnt == FULL_CNT);
    assign wr_idx     = full ? '0 : cnt[IDX_W-1:0];
    assign part_mask  = RATIO'(lane_mask(32'(cnt)));
    assign words_held = cnt;

    // Completed beat takes its newest word straight from rdata; partial beat zeroes unfilled lanes
    always_comb begin
        full_beat = '0;
        part_beat = '0;
        for (int k = 0; k < RATIO; k++) begin
            full_beat[k*MEMORY_WIDTH +: MEMORY_WIDTH] = (!full && k == RATIO - 1) ? rdata : acc[k];
            part_beat[k*MEMORY_WIDTH +: MEMORY_WIDTH] = part_mask[k] ? acc[k] : '0;
        end
    end

    // Pop control, beat completion, back-pressure and flush sequencing
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_pend_nxt = last_pend;
        r_en          = 1'b0;
        complete      = 1'b0;
        load          = 1'b0;
        load_data     = full_beat;
        load_mask     = '1;
        load_last     = 1'b0;
        if (state == ACC) begin
            r_en     = rrst_n && !r_empty && (!full || free);
            complete = full || (cnt == LAST_CNT && r_en);
            if (complete && free) begin
                load          = 1'b1;
                load_last     = flush || last_pend;
                last_pend_nxt = 1'b0;
                cnt_nxt       = (full && r_en) ? CNT_W'(1) : '0;
            end else if (complete) begin
                cnt_nxt       = FULL_CNT;
                last_pend_nxt = last_pend || flush;
            end else begin
                cnt_nxt = cnt + CNT_W'(r_en);
                if (flush && cnt != '0)
                    state_nxt = FLUSH;
            end
        end else if (free) begin
            load      = 1'b1;
            load_data = part_beat;
            load_mask = part_mask;
            load_last = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ACC;
        end
    end

    // State, word count and accumulator lanes
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= ACC;
            cnt       <= '0;
            last_pend <= 1'b0;
            for (int k = 0; k < RATIO; k++)
                acc[k] <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_pend <= last_pend_nxt;
            if (r_en)
                acc[wr_idx] <= rdata;
        end
    end

    fifo_rd_out_stage #(
        .DATA_W (BEAT_W),
        .LANES  (RATIO)
    ) u_out (
        .r_clk     (r_clk),
        .rrst_n    (rrst_n),
        .load      (load),
        .load_data (load_data),
        .load_mask (load_mask),
        .load_last (load_last),
        .out_ready (out_ready),
        .free      (free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_last  (out_last)
    );

endmodule
